// File: rtl/unified_mem_port_if.sv
// rtl/unified_mem_port_if.sv - unified memory bus between the core front end and memory
//
// Purpose: groups the single-ported memory request/response signals.
// Signals:
//   mem_req   - request valid (master -> slave)
//   mem_we    - write enable (master -> slave)
//   mem_be    - byte enables, one per 8-bit lane (master -> slave)
//   mem_addr  - word-aligned byte address (master -> slave)
//   mem_wdata - lane-positioned store data (master -> slave)
//   mem_rdata - read word (slave -> master)
//   mem_ready - request completes this cycle (slave -> master)
// Modports: master (front end), slave (memory).

interface unified_mem_port_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/unified_mem_port.sv
// rtl/unified_mem_port.sv - tick_tock memory front end sharing one memory between fetch and data
//
// Purpose: alternates a single-ported memory between instruction fetch
// (tick_tock = 1) and data load/store (tick_tock = 0), captures fetched
// instructions and extended load data, and stalls the core until the
// current phase completes.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pc_in             - fetch byte address
//   dmem_rd/dmem_wr   - MEM-stage load/store request (store wins)
//   dmem_funct3       - RV32I load/store size and sign
//   dmem_addr         - data byte address
//   dmem_wdata        - right-justified store data
//   tick_tock         - phase, 1 = FETCH, 0 = DATA
//   stall             - current phase not yet complete
//   inst_out          - last completed fetch word
//   load_data         - last completed load, extended
//   misalign_err      - misaligned access trapped this cycle
//   mem               - memory bus (master side)
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of forcing their low address bits to zero.

module unified_mem_port #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             dmem_rd,
  input  logic             dmem_wr,
  input  logic [2:0]       dmem_funct3,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  output logic             tick_tock,
  output logic             stall,
  output logic [XLEN-1:0]  inst_out,
  output logic [XLEN-1:0]  load_data,
  output logic             misalign_err,
  unified_mem_port_if.master mem
);

  logic            access;
  logic            is_store;
  logic            is_load;
  logic            sz_byte;
  logic            sz_half;
  logic            trap;
  logic            data_req;
  logic            phase_complete;
  logic [1:0]      off;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    is_store = dmem_wr;
    is_load  = dmem_rd & ~dmem_wr;
    access   = dmem_rd | dmem_wr;

    // funct3[2] set is only meaningful for loads (unsigned); on a store it is
    // undefined and falls back to a word access.
    sz_byte = (dmem_funct3[1:0] == 2'b00) && (is_load || !dmem_funct3[2]);
    sz_half = (dmem_funct3[1:0] == 2'b01) && (is_load || !dmem_funct3[2]);

    // Effective lane offset: offset bits below the access size are dropped,
    // which is also the non-trapping treatment of misaligned accesses.
    if (sz_byte)      off = dmem_addr[1:0];
    else if (sz_half) off = {dmem_addr[1], 1'b0};
    else              off = 2'b00;

`ifdef MISALIGN_TRAP_EN
    trap = access && ((sz_half && dmem_addr[0]) ||
                      (!sz_byte && !sz_half && (dmem_addr[1:0] != 2'b00)));
    misalign_err = ~rst & ~tick_tock & trap;
`else
    trap = 1'b0;
    misalign_err = 1'b0;
`endif

    data_req = access & ~trap;

    // mem_ready only counts while a request is actually issued.
    if (tick_tock || data_req) phase_complete = mem.mem_ready;
    else                       phase_complete = 1'b1;
    stall = ~phase_complete;

    mem.mem_req  = ~rst & (tick_tock | data_req);
    mem.mem_we   = ~tick_tock & is_store;
    mem.mem_addr = (tick_tock ? pc_in : dmem_addr) & ~(XLEN'(3));

    if (tick_tock || !is_store) mem.mem_be = 4'b1111;
    else if (sz_byte)           mem.mem_be = 4'b0001 << off;
    else if (sz_half)           mem.mem_be = off[1] ? 4'b1100 : 4'b0011;
    else                        mem.mem_be = 4'b1111;

    // Replicating narrow store data puts it on whichever lane is enabled.
    if (sz_byte)      mem.mem_wdata = {4{dmem_wdata[7:0]}};
    else if (sz_half) mem.mem_wdata = {2{dmem_wdata[15:0]}};
    else              mem.mem_wdata = dmem_wdata;

    lane = mem.mem_rdata >> {off, 3'b000};
    if (sz_byte)
      load_ext = {{(XLEN-8){~dmem_funct3[2] & lane[7]}}, lane[7:0]};
    else if (sz_half)
      load_ext = {{(XLEN-16){~dmem_funct3[2] & lane[15]}}, lane[15:0]};
    else
      load_ext = lane;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_tock <= 1'b1;
      inst_out  <= RESET_INST;
      load_data <= '0;
    end else if (phase_complete) begin
      tick_tock <= ~tick_tock;
      if (tick_tock)
        inst_out <= mem.mem_rdata;
      else if (is_load && data_req)
        load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_unified_mem_port.sv
// tb/tb_unified_mem_port.sv - self-checking bench for unified_mem_port

module tb_unified_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        tick_tock;
  logic        stall;
  logic [31:0] inst_out;
  logic [31:0] load_data;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  unified_mem_port_if #(.XLEN(32)) bus ();

  unified_mem_port #(.XLEN(32), .RESET_INST(32'h00000013)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .dmem_rd      (dmem_rd),
    .dmem_wr      (dmem_wr),
    .dmem_funct3  (dmem_funct3),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .tick_tock    (tick_tock),
    .stall        (stall),
    .inst_out     (inst_out),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .mem          (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3, input logic ld);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd4:    return ld ? 1 : 4;
      3'd5:    return ld ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  // Behavioural model: phase, last instruction and last load, stepped once per cycle.
  logic        m_valid = 1'b0;
  logic        m_tt;
  logic [31:0] m_inst;
  logic [31:0] m_load;

  initial begin
    forever begin
      logic        ld, st, acc, mis, skip, e_req, e_done, e_we, e_mis;
      logic [31:0] e_addr, e_be, e_wdata, mask, low, v;
      int          s, off, offa;
      @(negedge clk);
      ld   = dmem_rd && !dmem_wr;
      st   = dmem_wr;
      acc  = ld || st;
      s    = acc_size(dmem_funct3, ld);
      off  = int'(dmem_addr % 4);
      offa = (off / s) * s;
      mis  = (off % s) != 0;
`ifdef MISALIGN_TRAP_EN
      skip = acc && mis;
`else
      skip = 1'b0;
`endif
      mask    = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
      e_req   = !rst && (m_tt || (acc && !skip));
      e_done  = (m_tt || (acc && !skip)) ? bus.mem_ready : 1'b1;
      e_we    = !m_tt && st;
      e_addr  = m_tt ? (pc_in - (pc_in % 4)) : (dmem_addr - (dmem_addr % 4));
      e_be    = (m_tt || !st) ? 32'd15 : (((32'd1 << s) - 32'd1) << offa);
      low     = dmem_wdata & mask;
      e_wdata = 32'd0;
      for (int i = 0; i < 4 / s; i++) e_wdata = e_wdata | (low << (8 * s * i));
      e_mis   = !rst && !m_tt && skip;
      v = (bus.mem_rdata >> (8 * offa)) & mask;
      if (!dmem_funct3[2] && s < 4 && v[8*s-1]) v = v | ~mask;

      if (rst) check("mem_req_in_reset", {31'd0, bus.mem_req}, 32'd0);
      if (m_valid) begin
        check("tick_tock", {31'd0, tick_tock}, {31'd0, m_tt});
        check("inst_out", inst_out, m_inst);
        check("load_data", load_data, m_load);
        check("mem_req", {31'd0, bus.mem_req}, {31'd0, e_req});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
        if (!rst) check("stall", {31'd0, stall}, {31'd0, !e_done});
        if (e_req) begin
          check("mem_addr", bus.mem_addr, e_addr);
          check("mem_we", {31'd0, bus.mem_we}, {31'd0, e_we});
          check("mem_be", {28'd0, bus.mem_be}, e_be);
          if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
        end
      end

      if (rst) begin
        m_valid = 1'b1;
        m_tt    = 1'b1;
        m_inst  = 32'h00000013;
        m_load  = 32'd0;
      end else if (m_valid && e_done) begin
        if (m_tt) m_inst = bus.mem_rdata;
        else if (ld && !skip) m_load = v;
        m_tt = !m_tt;
      end
    end
  end

  task automatic step(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                      input logic [31:0] rdata, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; dmem_rd = rd; dmem_wr = wr; dmem_funct3 = f3;
    dmem_addr = a; dmem_wdata = wd; pc_in = pc;
    bus.mem_rdata = rdata; bus.mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dmem_rd = 1'b0; dmem_wr = 1'b0; dmem_funct3 = 3'd0;
    dmem_addr = 32'd0; dmem_wdata = 32'd0; pc_in = 32'd0;
    bus.mem_rdata = 32'h00500093; bus.mem_ready = 1'b1;

    step(1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    step(1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    check("lit_reset_tt", {31'd0, tick_tock}, 32'd1);
    check("lit_reset_inst", inst_out, 32'h00000013);
    check("lit_reset_load", load_data, 32'd0);

    // Zero-wait fetch/data alternation.
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    check("lit_tt_1", {31'd0, tick_tock}, 32'd1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    check("lit_tt_2", {31'd0, tick_tock}, 32'd0);
    check("lit_inst_first", inst_out, 32'h00500093);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    check("lit_tt_3", {31'd0, tick_tock}, 32'd1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00500093, 1);
    check("lit_tt_4", {31'd0, tick_tock}, 32'd0);

    // Fetch with three wait cycles.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h100, 32'hDEADBEEF, 0);
      check("lit_wait_stall", {31'd0, stall}, 32'd1);
      check("lit_wait_addr", bus.mem_addr, 32'h100);
      check("lit_wait_inst", inst_out, 32'h00500093);
    end
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h100, 32'h12345678, 1);
    check("lit_wait_done", {31'd0, stall}, 32'd0);

    // LB then LBU from lane 3.
    step(0, 1, 0, 3'd0, 32'h1003, 32'h0, 32'h104, 32'h80FF7F01, 1);
    check("lit_inst_after_wait", inst_out, 32'h12345678);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h104, 32'h00000013, 1);
    check("lit_lb", load_data, 32'hFFFFFF80);
    step(0, 1, 0, 3'd4, 32'h1003, 32'h0, 32'h108, 32'h80FF7F01, 1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h108, 32'h00000013, 1);
    check("lit_lbu", load_data, 32'h00000080);

    // SH to upper half.
    step(0, 0, 1, 3'd1, 32'h2002, 32'h0000BEEF, 32'h10C, 32'h0, 1);
    check("lit_sh_be", {28'd0, bus.mem_be}, 32'hC);
    check("lit_sh_wdata", bus.mem_wdata, 32'hBEEFBEEF);
    check("lit_sh_we", {31'd0, bus.mem_we}, 32'd1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h10C, 32'h00000013, 1);

    // Load and store together: store wins, with one wait cycle.
    step(0, 1, 1, 3'd2, 32'h3000, 32'hCAFEF00D, 32'h110, 32'h11111111, 0);
    check("lit_both_we", {31'd0, bus.mem_we}, 32'd1);
    check("lit_both_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 1, 3'd2, 32'h3000, 32'hCAFEF00D, 32'h110, 32'h11111111, 1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h110, 32'h00000013, 0);
    check("lit_both_load_kept", load_data, 32'h00000080);

    // Reset in the middle of a waiting fetch.
    step(1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h110, 32'h00000013, 0);
    check("lit_rst_req", {31'd0, bus.mem_req}, 32'd0);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00000093, 1);
    check("lit_rst_tt", {31'd0, tick_tock}, 32'd1);
    check("lit_rst_inst", inst_out, 32'h00000013);

    // Misaligned LW.
    step(0, 1, 0, 3'd2, 32'h4006, 32'h0, 32'h4, 32'hA5A5A5A5, 1);
`ifdef MISALIGN_TRAP_EN
    check("lit_lw_mis_err", {31'd0, misalign_err}, 32'd1);
    check("lit_lw_mis_req", {31'd0, bus.mem_req}, 32'd0);
`else
    check("lit_lw_mis_addr", bus.mem_addr, 32'h4004);
    check("lit_lw_mis_err", {31'd0, misalign_err}, 32'd0);
`endif
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h4, 32'h00000013, 1);
`ifdef MISALIGN_TRAP_EN
    check("lit_lw_mis_load", load_data, 32'd0);
`else
    check("lit_lw_mis_load", load_data, 32'hA5A5A5A5);
`endif

    // LH from upper half, then SB to lane 1.
    step(0, 1, 0, 3'd1, 32'h5002, 32'h0, 32'h8, 32'h80017FFF, 1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h8, 32'h00000013, 1);
    check("lit_lh", load_data, 32'hFFFF8001);
    step(0, 0, 1, 3'd0, 32'h6001, 32'h000000AB, 32'hC, 32'h0, 1);
    check("lit_sb_be", {28'd0, bus.mem_be}, 32'h2);
    check("lit_sb_wdata", bus.mem_wdata, 32'hABABABAB);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'hC, 32'h00000013, 1);
    step(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h10, 32'h00000013, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_port.md
Name: unified_mem_port

Overview:
- Single-ported memory front end for the pipelined RISC-V core.
- Owns the tick_tock phase signal that the program counter and pipeline registers consume.
- Alternates one unified memory between instruction fetch (phase 1) and data load/store (phase 0).
- Captures fetched instructions and aligned, extended load data, and stalls the core while memory is not ready.

Parameters:
- RESET_INST, 32'h00000013, value driven on inst_out after reset (ADDI x0,x0,0 NOP).
- XLEN, 32, data and address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  XLEN  fetch byte address, taken from the program counter output.
- dmem_rd  input  1  MEM-stage load request.
- dmem_wr  input  1  MEM-stage store request.
- dmem_funct3  input  3  load/store size and sign (RV32I encoding).
- dmem_addr  input  XLEN  data byte address.
- dmem_wdata  input  XLEN  store data, right-justified.
- tick_tock  output  1  phase: 1 = FETCH, 0 = DATA. The PC loads while tick_tock = 0.
- stall  output  1  high while the current phase has not completed.
- inst_out  output  XLEN  last completed fetch word.
- load_data  output  XLEN  last completed load, extended.
- misalign_err  output  1  see Optional Feature.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_addr  output  XLEN  word-aligned address (bits [1:0] = 0).
- mem_wdata  output  XLEN  lane-positioned store data.
- mem_rdata  input  XLEN  memory read word.
- mem_ready  input  1  memory completes the request this cycle.

Behaviour:
- Reset (rst = 1 at clk edge):
  - tick_tock = 1, inst_out = RESET_INST, load_data = 0, misalign_err = 0.
  - mem_req is forced 0 combinationally while rst = 1.
  - A reset mid-request abandons that request. The memory must tolerate mem_req dropping without a ready.
- Phase register: tick_tock toggles at a clk edge only when the current phase completes. Otherwise it holds.
- stall = ~phase_complete, combinational.
- FETCH phase (tick_tock = 1):
  - mem_req = 1, mem_we = 0, mem_be = 4'b1111, mem_addr = {pc_in[XLEN-1:2], 2'b00}.
  - Completes when mem_ready = 1; inst_out <= mem_rdata at that edge.
- DATA phase (tick_tock = 0):
  - With no access (dmem_rd = dmem_wr = 0): mem_req = 0 and the phase completes in 1 cycle.
  - dmem_wr has priority. If both are asserted, the access is a store and the load is ignored.
  - Store:
    - SB: mem_be = 4'b0001 << addr[1:0]; the byte is replicated on all lanes.
    - SH: mem_be = 4'b0011 (addr[1] = 0) or 4'b1100 (addr[1] = 1); the half is replicated.
    - SW: mem_be = 4'b1111.
    - mem_we = 1.
  - Load:
    - mem_we = 0, mem_be = 4'b1111.
    - On mem_ready, load_data <= the selected lane, extended: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - An undefined funct3 is treated as a word access.
- Request stability: mem_addr, mem_we, mem_be and mem_wdata are held constant while mem_req = 1 and mem_ready = 0. mem_ready is ignored when mem_req = 0.
- Latency:
  - Zero-wait memory (mem_ready tied 1): 2 cycles per instruction, one FETCH plus one DATA.
  - Each wait cycle adds 1 stall cycle to the current phase.
- inst_out and load_data hold their values between completions.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, is misaligned.
  - The access issues no mem_req and the DATA phase completes in 1 cycle.
  - misalign_err pulses 1 for that cycle; load_data is unchanged.
- Undefined:
  - The misaligned offset bits are forced to 0 (halfword: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds.
  - misalign_err is tied 0.

Test Plan:
- Reset, then mem_ready = 1, pc_in = 0, mem_rdata = 32'h00500093 -> tick_tock sequence 1,0,1,0. inst_out = 32'h00500093 after the first edge. stall stays 0.
- FETCH with mem_ready low for 3 cycles -> stall = 1 for 3 cycles, tick_tock holds 1, mem_addr is stable, inst_out updates only on the ready cycle.
- LB at addr 0x...03, mem_rdata = 32'h80FF7F01 -> load_data = 32'hFFFFFF80. The same access as LBU -> 32'h00000080.
- SH at addr 0x...02, dmem_wdata = 32'h0000BEEF -> mem_be = 4'b1100, mem_wdata = 32'hBEEFBEEF, mem_we = 1.
- dmem_rd = dmem_wr = 1 -> store performed, load_data unchanged. rst asserted mid-wait -> tick_tock = 1 and inst_out = RESET_INST after the edge.
- LW at addr 0x...06:
  - With MISALIGN_TRAP_EN: misalign_err = 1, no mem_req.
  - Without: mem_addr = 0x...04 and misalign_err = 0.
